// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / peripheral-page responder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package dmem_mmio_pkg;

    // Default base address of the peripheral page (low byte must be zero)
    localparam logic [31:0] MMIO_BASE_DEF = 32'h0000_1000;

    // Byte offsets of the peripheral registers within the page
    localparam logic [7:0] GPIO_OFF  = 8'h00;
    localparam logic [7:0] TCNT_OFF  = 8'h04;
    localparam logic [7:0] TCMP_OFF  = 8'h08;
    localparam logic [7:0] TCTRL_OFF = 8'h0C;
    localparam logic [7:0] CYCLE_OFF = 8'h10;

    // Bit positions inside TCTRL
    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_RELOAD = 1;
    localparam int TCTRL_FLAG   = 2;

endpackage

// File: rtl/dmem_mmio_if.sv
// Data-memory bus between the datapath (master) and the memory responder (slave).
// Latency: reads are combinational, writes land on the next rising edge.
// Backpressure: none; every access completes in the cycle it is presented.
interface dmem_mmio_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output we, output a, output wd, input rd);
    modport slave  (input we, input a, input wd, output rd);
endinterface

// File: rtl/mmio_timer.sv
// 32-bit timer with compare register, enable/reload control and sticky match flag.
// Latency: register writes and count updates visible one cycle after the edge.
// Backpressure: none; write enables are accepted every cycle.
module mmio_timer
    import dmem_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tcnt_we,
    input  logic        tcmp_we,
    input  logic        tctrl_we,
    input  logic [31:0] wd,
    output logic [31:0] tcnt,
    output logic [31:0] tcmp,
    output logic        en,
    output logic        reload,
    output logic        flag
);

    logic match;

    // Match is only evaluated while counting; uses the pre-edge compare value
    always_comb begin
        match = en && (tcnt == tcmp);
    end

    // Counter, compare, control and flag state; software writes beat hardware updates,
    // except a same-cycle match which beats a flag clear
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt   <= '0;
            tcmp   <= '0;
            en     <= 1'b0;
            reload <= 1'b0;
            flag   <= 1'b0;
        end else begin
            if (tcnt_we) begin
                tcnt <= wd;
            end else if (en) begin
                tcnt <= (match && reload) ? 32'd0 : tcnt + 32'd1;
            end

            if (tcmp_we) begin
                tcmp <= wd;
            end

            if (tctrl_we) begin
                en     <= wd[TCTRL_EN];
                reload <= wd[TCTRL_RELOAD];
            end

            if (match) begin
                flag <= 1'b1;
            end else if (tctrl_we && wd[TCTRL_FLAG]) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus peripheral page (GPIO, timer, cycle counter) on the datapath's memory port.
// Latency: loads combinational (0 cycles); stores and peripheral updates visible next cycle.
// Backpressure: none; every access completes in the cycle it is presented.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter int          GPIO_W    = 8,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    dmem_mmio_if.slave        bus,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    localparam logic [2:0] IDX_GPIO  = GPIO_OFF[4:2];
    localparam logic [2:0] IDX_TCNT  = TCNT_OFF[4:2];
    localparam logic [2:0] IDX_TCMP  = TCMP_OFF[4:2];
    localparam logic [2:0] IDX_TCTRL = TCTRL_OFF[4:2];
    localparam logic [2:0] IDX_CYCLE = CYCLE_OFF[4:2];

    logic [31:0]       mem [DEPTH];
    logic              ram_hit;
    logic              mmio_hit;
    logic [AW-1:0]     ram_idx;
    logic [2:0]        reg_idx;
    logic              reg_we;
    logic [GPIO_W-1:0] gpio;
    logic [31:0]       cycle;
    logic [31:0]       tcnt;
    logic [31:0]       tcmp;
    logic              t_en;
    logic              t_reload;
    logic              t_flag;
    logic [31:0]       tctrl_rd;
    logic [31:0]       rd_val;

    // Address decode: low RAM window, peripheral page, everything else is a hole
    always_comb begin
        ram_hit  = bus.a < RAM_BYTES;
        mmio_hit = bus.a[31:8] == MMIO_BASE[31:8];
        ram_idx  = bus.a[AW+1:2];
        reg_idx  = bus.a[4:2];
        reg_we   = bus.we && mmio_hit;
    end

    // RAM store; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (bus.we && ram_hit) begin
            mem[ram_idx] <= bus.wd;
        end
    end

    // GPIO output register
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio <= '0;
        end else if (reg_we && reg_idx == IDX_GPIO) begin
            gpio <= bus.wd[GPIO_W-1:0];
        end
    end

    // Free-running cycle counter, read-only, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    mmio_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .tcnt_we  (reg_we && reg_idx == IDX_TCNT),
        .tcmp_we  (reg_we && reg_idx == IDX_TCMP),
        .tctrl_we (reg_we && reg_idx == IDX_TCTRL),
        .wd       (bus.wd),
        .tcnt     (tcnt),
        .tcmp     (tcmp),
        .en       (t_en),
        .reload   (t_reload),
        .flag     (t_flag)
    );

    // Assemble TCTRL read view; undefined bits read zero
    always_comb begin
        tctrl_rd               = '0;
        tctrl_rd[TCTRL_EN]     = t_en;
        tctrl_rd[TCTRL_RELOAD] = t_reload;
        tctrl_rd[TCTRL_FLAG]   = t_flag;
    end

    // Load mux: pre-edge state, so a read during a write returns the old value
    always_comb begin
        rd_val = '0;
        if (ram_hit) begin
            rd_val = mem[ram_idx];
        end else if (mmio_hit) begin
            case (reg_idx)
                IDX_GPIO:  rd_val = 32'(gpio);
                IDX_TCNT:  rd_val = tcnt;
                IDX_TCMP:  rd_val = tcmp;
                IDX_TCTRL: rd_val = tctrl_rd;
                IDX_CYCLE: rd_val = cycle;
                default:   rd_val = '0;
            endcase
        end
    end

    assign bus.rd   = rd_val;
    assign gpio_out = gpio;
    assign irq      = t_flag;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, decode holes, GPIO, timer and cycle counter.
// Latency: inputs driven 1ns after the rising edge, outputs sampled before the next edge.
// Backpressure: n/a.
module tb_dmem_mmio;

    logic       clk;
    logic       reset;
    logic [7:0] gpio_out;
    logic       irq;
    int         n_checks;
    int         n_errors;

    dmem_mmio_if bus ();

    dmem_mmio #(
        .DEPTH     (64),
        .GPIO_W    (8),
        .MMIO_BASE (32'h0000_1000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.we = 1'b1;
        bus.a  = addr;
        bus.wd = data;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.we = 1'b0;
        bus.a  = addr;
        #1;
        check(tag, bus.rd, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        bus.we   = 1'b0;
        bus.a    = '0;
        bus.wd   = '0;
        repeat (3) tick();

        // Reset state
        check("rst_gpio", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rd_chk("rst_cycle", 32'h1010, 32'h0);

        // Cycle counter after release
        reset = 1'b0;
        tick();
        rd_chk("cycle_1", 32'h1010, 32'd1);
        tick();
        rd_chk("cycle_2", 32'h1010, 32'd2);

        // RAM: write, read-during-write, byte-offset alias, hole
        wr(32'h0000_0000, 32'h1234_5678);
        wr(32'h0000_0008, 32'h1111_1111);
        bus.we = 1'b1;
        bus.a  = 32'h0000_0008;
        bus.wd = 32'hDEAD_BEEF;
        #1;
        check("ram_rdw_old", bus.rd, 32'h1111_1111);
        tick();
        bus.we = 1'b0;
        rd_chk("ram_rd_08", 32'h0000_0008, 32'hDEAD_BEEF);
        rd_chk("ram_rd_0b", 32'h0000_000B, 32'hDEAD_BEEF);
        wr(32'h0000_0800, 32'hFFFF_FFFF);
        rd_chk("hole_rd", 32'h0000_0800, 32'h0);
        rd_chk("ram_no_alias", 32'h0000_0000, 32'h1234_5678);

        // GPIO
        wr(32'h0000_1000, 32'h0000_01A5);
        check("gpio_out", 32'(gpio_out), 32'h0000_00A5);
        rd_chk("gpio_rd", 32'h0000_1000, 32'h0000_00A5);

        // Unused peripheral slot
        wr(32'h0000_1014, 32'hFFFF_FFFF);
        rd_chk("mmio_hole", 32'h0000_1014, 32'h0);

        // Timer with reload: 0,1,2,3,0 and flag after the match
        wr(32'h0000_1008, 32'd3);
        wr(32'h0000_100C, 32'h3);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] exp_cnt;
            exp_cnt = (i == 4) ? 32'd0 : 32'(i);
            rd_chk($sformatf("tcnt_reload_%0d", i), 32'h0000_1004, exp_cnt);
            check($sformatf("irq_reload_%0d", i), 32'(irq), (i == 4) ? 32'd1 : 32'd0);
            if (i != 4) tick();
        end

        // Flag clear keeps EN/RELOAD (count 0 -> 1 at this edge)
        wr(32'h0000_100C, 32'h7);
        check("irq_cleared", 32'(irq), 32'h0);
        rd_chk("tctrl_after_clr", 32'h0000_100C, 32'h3);

        // Match coinciding with a clear: set wins
        tick();
        tick();
        rd_chk("tcnt_pre_coinc", 32'h0000_1004, 32'd3);
        wr(32'h0000_100C, 32'h7);
        check("irq_set_wins", 32'(irq), 32'h1);
        rd_chk("tcnt_post_coinc", 32'h0000_1004, 32'd0);

        // Software TCNT write while counting
        wr(32'h0000_1004, 32'h10);
        rd_chk("tcnt_wr", 32'h0000_1004, 32'h10);
        tick();
        rd_chk("tcnt_wr_inc", 32'h0000_1004, 32'h11);

        // Wrap without reload, then match at 5
        wr(32'h0000_100C, 32'h4);
        check("irq_off", 32'(irq), 32'h0);
        wr(32'h0000_1004, 32'hFFFF_FFFF);
        wr(32'h0000_1008, 32'd5);
        wr(32'h0000_100C, 32'h1);
        rd_chk("tcnt_wrap_start", 32'h0000_1004, 32'hFFFF_FFFF);
        rd_chk("tcmp_rd", 32'h0000_1008, 32'd5);
        for (int i = 0; i < 6; i++) begin
            tick();
            rd_chk($sformatf("tcnt_wrap_%0d", i), 32'h0000_1004, 32'(i));
            check($sformatf("irq_wrap_%0d", i), 32'(irq), 32'h0);
        end
        tick();
        check("irq_match5", 32'(irq), 32'h1);
        rd_chk("tcnt_after5", 32'h0000_1004, 32'd6);

        // Reset mid-count
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_chk("rst2_tcnt", 32'h0000_1004, 32'h0);
        rd_chk("rst2_tctrl", 32'h0000_100C, 32'h0);
        rd_chk("rst2_cycle", 32'h0000_1010, 32'h0);
        check("rst2_irq", 32'(irq), 32'h0);
        check("rst2_gpio", 32'(gpio_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
